// File: rtl/decode_queue_if.sv
// Fetch-side and issue-side handshake bundle for the decode queue.
// The queue uses the slave view. The fetch/issue side uses the master view.
interface decode_queue_if #(
   parameter int FETCH_W = 2,
   parameter int ISSUE_W = 2
);
   logic [FETCH_W-1:0]    in_valid;
   logic [FETCH_W*32-1:0] in_instr;
   logic [FETCH_W*32-1:0] in_pc;
   logic                  in_ready;
   logic [ISSUE_W-1:0]    out_valid;
   logic [ISSUE_W-1:0]    out_take;
   logic [ISSUE_W*32-1:0] out_instr;
   logic [ISSUE_W*32-1:0] out_pc;
   logic [ISSUE_W*24-1:0] out_ctrl;

   modport master (
      output in_valid, in_instr, in_pc, out_take,
      input  in_ready, out_valid, out_instr, out_pc, out_ctrl
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_take,
      output in_ready, out_valid, out_instr, out_pc, out_ctrl
   );
endinterface

// File: rtl/decode_queue.sv
// Multi-lane instruction buffer with an LA32R pre-decoder at enqueue.
// ctrl[23:0] = {reg_we, mem_rd, mem_we, is_branch, is_jirl, is_bl, is_csr, is_tlb, is_ertn, is_idle, syscall, brk, ine, ipe, unsign_ld, size[1:0], aluop[4:0], unsign_imm, csr_xchg}
module decode_queue #(
   parameter int FETCH_W   = 2,
   parameter int ISSUE_W   = 2,
   parameter int DEPTH     = 8,
   parameter int CHECK_PLV = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [1:0]         plv,
   decode_queue_if.slave      dq
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_SLT  = 5'd2;
   localparam logic [4:0] ALU_SLTU = 5'd3;
   localparam logic [4:0] ALU_AND  = 5'd4;
   localparam logic [4:0] ALU_OR   = 5'd5;
   localparam logic [4:0] ALU_XOR  = 5'd6;
   localparam logic [4:0] ALU_NOR  = 5'd7;
   localparam logic [4:0] ALU_SLL  = 5'd8;
   localparam logic [4:0] ALU_SRL  = 5'd9;
   localparam logic [4:0] ALU_SRA  = 5'd10;
   localparam logic [4:0] ALU_MUL  = 5'd11;
   localparam logic [4:0] ALU_MULH = 5'd12;
   localparam logic [4:0] ALU_MULHU= 5'd13;
   localparam logic [4:0] ALU_DIV  = 5'd14;
   localparam logic [4:0] ALU_MOD  = 5'd15;
   localparam logic [4:0] ALU_DIVU = 5'd16;
   localparam logic [4:0] ALU_MODU = 5'd17;
   localparam logic [4:0] ALU_LUI  = 5'd18;

   logic [31:0]   instr_mem [DEPTH];
   logic [31:0]   pc_mem    [DEPTH];
   logic [23:0]   ctrl_mem  [DEPTH];
   logic [PW-1:0] wptr, rptr, cnt;
   logic [PW-1:0] enq_n, deq_n;
   logic          ready;
   logic [ISSUE_W-1:0] valid;
   logic [23:0]   lane_ctrl [FETCH_W];

   // Length of the run of 1s starting at bit 0; lanes past a gap never count.
   function automatic logic [PW-1:0] prefix_len(input logic [3:0] v);
      logic [PW-1:0] n;
      logic          run;
      n   = '0;
      run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run = run & v[i];
         if (run) n = n + PW'(1);
      end
      return n;
   endfunction

   function automatic logic [23:0] decode(input logic [31:0] ins, input logic [1:0] lvl);
      logic       ok, we, rd, wr, br, jirl, bl, csr, tlb, ertn, idle, sys, brk, ipe, uld, uimm, xchg;
      logic [1:0] sz;
      logic [4:0] op;
      {ok, we, rd, wr, br, jirl, bl, csr, tlb, ertn, idle, sys, brk, ipe, uld, uimm, xchg} = '0;
      sz = 2'd0;
      op = ALU_ADD;

      case (ins[31:15])
         17'h00020: begin ok = 1'b1; we = 1'b1; op = ALU_ADD;   end
         17'h00022: begin ok = 1'b1; we = 1'b1; op = ALU_SUB;   end
         17'h00024: begin ok = 1'b1; we = 1'b1; op = ALU_SLT;   end
         17'h00025: begin ok = 1'b1; we = 1'b1; op = ALU_SLTU;  end
         17'h00028: begin ok = 1'b1; we = 1'b1; op = ALU_NOR;   end
         17'h00029: begin ok = 1'b1; we = 1'b1; op = ALU_AND;   end
         17'h0002A: begin ok = 1'b1; we = 1'b1; op = ALU_OR;    end
         17'h0002B: begin ok = 1'b1; we = 1'b1; op = ALU_XOR;   end
         17'h0002E: begin ok = 1'b1; we = 1'b1; op = ALU_SLL;   end
         17'h0002F: begin ok = 1'b1; we = 1'b1; op = ALU_SRL;   end
         17'h00030: begin ok = 1'b1; we = 1'b1; op = ALU_SRA;   end
         17'h00038: begin ok = 1'b1; we = 1'b1; op = ALU_MUL;   end
         17'h00039: begin ok = 1'b1; we = 1'b1; op = ALU_MULH;  end
         17'h0003A: begin ok = 1'b1; we = 1'b1; op = ALU_MULHU; end
         17'h00040: begin ok = 1'b1; we = 1'b1; op = ALU_DIV;   end
         17'h00041: begin ok = 1'b1; we = 1'b1; op = ALU_MOD;   end
         17'h00042: begin ok = 1'b1; we = 1'b1; op = ALU_DIVU;  end
         17'h00043: begin ok = 1'b1; we = 1'b1; op = ALU_MODU;  end
         17'h00054: begin ok = 1'b1; brk = 1'b1; end
         17'h00056: begin ok = 1'b1; sys = 1'b1; end
         17'h00081: begin ok = 1'b1; we = 1'b1; op = ALU_SLL; end
         17'h00089: begin ok = 1'b1; we = 1'b1; op = ALU_SRL; end
         17'h00091: begin ok = 1'b1; we = 1'b1; op = ALU_SRA; end
         17'h00C91: begin ok = 1'b1; idle = 1'b1; end
         17'h00C93: begin ok = 1'b1; tlb = 1'b1; end
         default: ;
      endcase

      // TLB maintenance and ertn have no operand fields, so match whole words.
      case (ins)
         32'h06482800, 32'h06482C00, 32'h06483000, 32'h06483400: begin ok = 1'b1; tlb = 1'b1; end
         32'h06483800: begin ok = 1'b1; ertn = 1'b1; end
         default: ;
      endcase

      case (ins[31:22])
         10'h008: begin ok = 1'b1; we = 1'b1; op = ALU_SLT;  end
         10'h009: begin ok = 1'b1; we = 1'b1; op = ALU_SLTU; end
         10'h00A: begin ok = 1'b1; we = 1'b1; op = ALU_ADD;  end
         10'h00D: begin ok = 1'b1; we = 1'b1; op = ALU_AND; uimm = 1'b1; end
         10'h00E: begin ok = 1'b1; we = 1'b1; op = ALU_OR;  uimm = 1'b1; end
         10'h00F: begin ok = 1'b1; we = 1'b1; op = ALU_XOR; uimm = 1'b1; end
         10'h0A0: begin ok = 1'b1; we = 1'b1; rd = 1'b1; sz = 2'd0; end
         10'h0A1: begin ok = 1'b1; we = 1'b1; rd = 1'b1; sz = 2'd1; end
         10'h0A2: begin ok = 1'b1; we = 1'b1; rd = 1'b1; sz = 2'd2; end
         10'h0A4: begin ok = 1'b1; wr = 1'b1; sz = 2'd0; end
         10'h0A5: begin ok = 1'b1; wr = 1'b1; sz = 2'd1; end
         10'h0A6: begin ok = 1'b1; wr = 1'b1; sz = 2'd2; end
         10'h0A8: begin ok = 1'b1; we = 1'b1; rd = 1'b1; uld = 1'b1; sz = 2'd0; end
         10'h0A9: begin ok = 1'b1; we = 1'b1; rd = 1'b1; uld = 1'b1; sz = 2'd1; end
         default: ;
      endcase

      case (ins[31:24])
         8'h04: begin
            ok = 1'b1; we = 1'b1; csr = 1'b1;
            xchg = (ins[9:5] != 5'd0) && (ins[9:5] != 5'd1);
         end
         8'h20: begin ok = 1'b1; we = 1'b1; rd = 1'b1; sz = 2'd2; end
         8'h21: begin ok = 1'b1; wr = 1'b1; sz = 2'd2; end
         default: ;
      endcase

      case (ins[31:25])
         7'h0A: begin ok = 1'b1; we = 1'b1; op = ALU_LUI; end
         7'h0E: begin ok = 1'b1; we = 1'b1; op = ALU_ADD; end
         default: ;
      endcase

      case (ins[31:26])
         6'h13: begin ok = 1'b1; we = 1'b1; br = 1'b1; jirl = 1'b1; end
         6'h14: begin ok = 1'b1; br = 1'b1; end
         6'h15: begin ok = 1'b1; we = 1'b1; br = 1'b1; bl = 1'b1; end
         6'h16, 6'h17: begin ok = 1'b1; br = 1'b1; op = ALU_SUB;  end
         6'h18, 6'h19: begin ok = 1'b1; br = 1'b1; op = ALU_SLT;  end
         6'h1A, 6'h1B: begin ok = 1'b1; br = 1'b1; op = ALU_SLTU; end
         default: ;
      endcase

      if (!ok) return 24'h000800;
      ipe = (CHECK_PLV != 0) && (lvl != 2'd0) && (csr || tlb || ertn || idle);
      return {we, rd, wr, br, jirl, bl, csr, tlb, ertn, idle, sys, brk, 1'b0, ipe,
              uld, sz, op, uimm, xchg};
   endfunction

   always_comb begin
      ready = (PW'(DEPTH) - cnt) >= PW'(FETCH_W);
      enq_n = ready ? prefix_len(4'(dq.in_valid)) : '0;
      deq_n = prefix_len(4'(dq.out_take & valid));
   end

   always_comb begin
      for (int i = 0; i < FETCH_W; i++) begin
         lane_ctrl[i] = decode(dq.in_instr[i*32 +: 32], plv);
      end
   end

   always_comb begin
      valid        = '0;
      dq.out_instr = '0;
      dq.out_pc    = '0;
      dq.out_ctrl  = '0;
      for (int i = 0; i < ISSUE_W; i++) begin
         valid[i]                = cnt > PW'(i);
         dq.out_instr[i*32 +: 32] = instr_mem[rptr[AW-1:0] + AW'(i)];
         dq.out_pc[i*32 +: 32]    = pc_mem[rptr[AW-1:0] + AW'(i)];
         dq.out_ctrl[i*24 +: 24]  = ctrl_mem[rptr[AW-1:0] + AW'(i)];
      end
   end

   assign dq.out_valid = valid;
   assign dq.in_ready  = ready;

   // Payload storage carries no reset; only the pointers define what is live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_W; i++) begin
         if (!flush && (PW'(i) < enq_n)) begin
            instr_mem[wptr[AW-1:0] + AW'(i)] <= dq.in_instr[i*32 +: 32];
            pc_mem[wptr[AW-1:0] + AW'(i)]    <= dq.in_pc[i*32 +: 32];
            ctrl_mem[wptr[AW-1:0] + AW'(i)]  <= lane_ctrl[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         cnt  <= '0;
         wptr <= '0;
         rptr <= '0;
      end else begin
         cnt  <= cnt + enq_n - deq_n;
         wptr <= wptr + enq_n;
         rptr <= rptr + deq_n;
      end
   end
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: decode bundles, queue handshakes, wrap, flush and reset.
module tb_decode_queue;
   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic [1:0] plv;
   int         checks = 0;
   int         errors = 0;

   decode_queue_if #(.FETCH_W(2), .ISSUE_W(2)) bus ();

   decode_queue #(.FETCH_W(2), .ISSUE_W(2), .DEPTH(8), .CHECK_PLV(1)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .plv   (plv),
      .dq    (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [1:0] v, input logic [31:0] i1, input logic [31:0] i0,
                        input logic [31:0] p1, input logic [31:0] p0);
      bus.in_valid = v;
      bus.in_instr = {i1, i0};
      bus.in_pc    = {p1, p0};
      step();
      bus.in_valid = 2'b00;
   endtask

   task automatic take(input logic [1:0] t);
      bus.out_take = t;
      step();
      bus.out_take = 2'b00;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; plv = 2'd0;
      bus.in_valid = 2'b00; bus.in_instr = '0; bus.in_pc = '0; bus.out_take = 2'b00;
      step(); step();
      checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b exp 00", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.in_ready); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_alu();
      offer(2'b01, 32'h0, 32'h00100C41, 32'h0, 32'h1C000000);
      checks++; if (bus.out_valid !== 2'b01) begin errors++; $display("FAIL alu_valid got %b exp 01", bus.out_valid); end
      checks++; if (bus.out_ctrl[23:0] !== 24'h800000) begin errors++; $display("FAIL alu_ctrl got %h exp 800000", bus.out_ctrl[23:0]); end
      checks++; if (bus.out_pc[31:0] !== 32'h1C000000) begin errors++; $display("FAIL alu_pc got %h exp 1c000000", bus.out_pc[31:0]); end
      take(2'b01);
      checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL alu_drain got %b exp 00", bus.out_valid); end
   endtask

   task automatic test_mem_sys();
      offer(2'b11, 32'h002B0000, 32'h288020A4, 32'h1C000008, 32'h1C000004);
      checks++; if (bus.out_valid !== 2'b11) begin errors++; $display("FAIL memsys_valid got %b exp 11", bus.out_valid); end
      checks++; if (bus.out_ctrl[23:0] !== 24'hC00100) begin errors++; $display("FAIL ldw_ctrl got %h exp c00100", bus.out_ctrl[23:0]); end
      checks++; if (bus.out_ctrl[47:24] !== 24'h002000) begin errors++; $display("FAIL syscall_ctrl got %h exp 002000", bus.out_ctrl[47:24]); end
      checks++; if (bus.out_instr[63:32] !== 32'h002B0000) begin errors++; $display("FAIL syscall_instr got %h exp 002b0000", bus.out_instr[63:32]); end
      take(2'b11);
      checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL memsys_drain got %b exp 00", bus.out_valid); end
   endtask

   task automatic test_ine_plv();
      plv = 2'd3;
      offer(2'b11, 32'h04000000, 32'h00000000, 32'h14, 32'h10);
      checks++; if (bus.out_ctrl[23:0] !== 24'h000800) begin errors++; $display("FAIL ine_ctrl got %h exp 000800", bus.out_ctrl[23:0]); end
      checks++; if (bus.out_ctrl[47:24] !== 24'h820400) begin errors++; $display("FAIL csr_plv3 got %h exp 820400", bus.out_ctrl[47:24]); end
      take(2'b11);
      plv = 2'd0;
      offer(2'b01, 32'h0, 32'h04000000, 32'h0, 32'h18);
      checks++; if (bus.out_ctrl[23:0] !== 24'h820000) begin errors++; $display("FAIL csr_plv0 got %h exp 820000", bus.out_ctrl[23:0]); end
      take(2'b01);
   endtask

   task automatic test_decode_misc();
      offer(2'b11, 32'h03400000, 32'h2A000000, 32'h24, 32'h20);
      checks++; if (bus.out_ctrl[23:0] !== 24'hC00200) begin errors++; $display("FAIL ldbu_ctrl got %h exp c00200", bus.out_ctrl[23:0]); end
      checks++; if (bus.out_ctrl[47:24] !== 24'h800012) begin errors++; $display("FAIL andi_ctrl got %h exp 800012", bus.out_ctrl[47:24]); end
      take(2'b11);
      plv = 2'd3;
      offer(2'b11, 32'h06483800, 32'h54000000, 32'h2C, 32'h28);
      plv = 2'd0;
      checks++; if (bus.out_ctrl[23:0] !== 24'h940000) begin errors++; $display("FAIL bl_ctrl got %h exp 940000", bus.out_ctrl[23:0]); end
      checks++; if (bus.out_ctrl[47:24] !== 24'h008400) begin errors++; $display("FAIL ertn_ctrl got %h exp 008400", bus.out_ctrl[47:24]); end
      take(2'b11);
   endtask

   task automatic test_full_wrap();
      logic [31:0] base;
      base = 32'h1000;
      for (int k = 0; k < 4; k++) begin
         offer(2'b11, 32'h00100C41, 32'h00100C41, base + 32'(8*k) + 32'd4, base + 32'(8*k));
         checks++;
         if (bus.in_ready !== (k < 3)) begin errors++; $display("FAIL fill_ready k=%0d got %b exp %b", k, bus.in_ready, (k < 3)); end
      end
      offer(2'b11, 32'h00100C41, 32'h00100C41, 32'h904, 32'h900);
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.in_ready); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (bus.out_valid !== 2'b11 || bus.out_pc[31:0] !== base + 32'(8*k) || bus.out_pc[63:32] !== base + 32'(8*k) + 32'd4) begin
            errors++; $display("FAIL wrap_order k=%0d got %b %h %h exp 11 %h %h", k, bus.out_valid,
                               bus.out_pc[31:0], bus.out_pc[63:32], base + 32'(8*k), base + 32'(8*k) + 32'd4);
         end
         take(2'b11);
         if (k == 0) begin
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b exp 1", bus.in_ready); end
         end
      end
      checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL full_dropped got %b exp 00", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] base;
      base = 32'h2000;
      offer(2'b11, 32'h00100C41, 32'h00100C41, base + 32'd4, base);
      for (int k = 1; k < 4; k++) begin
         checks++;
         if (bus.out_pc[31:0] !== base + 32'(8*(k-1))) begin errors++; $display("FAIL b2b_pc k=%0d got %h exp %h", k, bus.out_pc[31:0], base + 32'(8*(k-1))); end
         bus.out_take = 2'b11;
         offer(2'b11, 32'h00100C41, 32'h00100C41, base + 32'(8*k) + 32'd4, base + 32'(8*k));
         bus.out_take = 2'b00;
      end
      checks++;
      if (bus.out_valid !== 2'b11 || bus.out_pc[63:32] !== base + 32'd28) begin
         errors++; $display("FAIL b2b_last got %b %h exp 11 %h", bus.out_valid, bus.out_pc[63:32], base + 32'd28);
      end
      take(2'b11);
   endtask

   task automatic test_nonprefix();
      offer(2'b10, 32'h00100C41, 32'h00100C41, 32'h3004, 32'h3000);
      checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL nonprefix_in got %b exp 00", bus.out_valid); end
      take(2'b11);
      offer(2'b11, 32'h00100C41, 32'h00100C41, 32'h3004, 32'h3000);
      take(2'b10);
      checks++;
      if (bus.out_valid !== 2'b11 || bus.out_pc[31:0] !== 32'h3000) begin
         errors++; $display("FAIL nonprefix_take got %b %h exp 11 00003000", bus.out_valid, bus.out_pc[31:0]);
      end
      take(2'b11);
      offer(2'b01, 32'h0, 32'h00100C41, 32'h0, 32'h3008);
      checks++;
      if (bus.out_valid !== 2'b01 || bus.out_pc[31:0] !== 32'h3008) begin
         errors++; $display("FAIL empty_take got %b %h exp 01 00003008", bus.out_valid, bus.out_pc[31:0]);
      end
      take(2'b01);
   endtask

   task automatic test_flush();
      offer(2'b11, 32'h00100C41, 32'h00100C41, 32'h4004, 32'h4000);
      offer(2'b11, 32'h00100C41, 32'h00100C41, 32'h400C, 32'h4008);
      offer(2'b01, 32'h0, 32'h00100C41, 32'h0, 32'h4010);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL cnt5_ready got %b exp 1", bus.in_ready); end
      flush = 1'b1;
      bus.out_take = 2'b11;
      offer(2'b11, 32'h00100C41, 32'h00100C41, 32'h4FF4, 32'h4FF0);
      flush = 1'b0;
      bus.out_take = 2'b00;
      checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL flush_valid got %b exp 00", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", bus.in_ready); end
      offer(2'b01, 32'h0, 32'h00100C41, 32'h0, 32'h5000);
      checks++;
      if (bus.out_valid !== 2'b01 || bus.out_pc[31:0] !== 32'h5000) begin
         errors++; $display("FAIL post_flush got %b %h exp 01 00005000", bus.out_valid, bus.out_pc[31:0]);
      end
   endtask

   task automatic test_rst_mid();
      offer(2'b11, 32'h00100C41, 32'h00100C41, 32'h5008, 32'h5004);
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.out_valid !== 2'b00) begin errors++; $display("FAIL rst_mid_valid got %b exp 00", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", bus.in_ready); end
      #3 rst = 1'b0;
      step();
      offer(2'b11, 32'h00100C41, 32'h00100C41, 32'h6004, 32'h6000);
      checks++;
      if (bus.out_valid !== 2'b11 || bus.out_pc[31:0] !== 32'h6000 || bus.out_pc[63:32] !== 32'h6004) begin
         errors++; $display("FAIL post_rst got %b %h %h exp 11 00006000 00006004", bus.out_valid, bus.out_pc[31:0], bus.out_pc[63:32]);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mem_sys();
      test_ine_plv();
      test_decode_misc();
      test_full_wrap();
      test_back_to_back();
      test_nonprefix();
      test_flush();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
